// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the byte-wide UART.
// The receiver and the transmitter use the same state type.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_W               = 8;

    // WAIT_HIGH is only reached by the receiver after a framing error.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/uart_if.sv
// UART pin and byte-handshake bundle.
// The host side drives rx/tx_data/transmit; the UART side drives the rest.
interface uart_if;
    import uart_pkg::*;

    logic              rx;
    logic              tx;
    logic [DATA_W-1:0] rx_data;
    logic              rx_done;
    logic              rx_err;
    logic [DATA_W-1:0] tx_data;
    logic              transmit;
    logic              tx_done;
    logic              tx_busy;

    modport master (
        output rx, tx_data, transmit,
        input  tx, rx_data, rx_done, rx_err, tx_done, tx_busy
    );

    modport slave (
        input  rx, tx_data, transmit,
        output tx, rx_data, rx_done, rx_err, tx_done, tx_busy
    );

endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchroniser on rx, then a mid-bit sampling FSM
// that yields rx_data with a one-cycle rx_done or rx_err strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_done,
    output logic              rx_err
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic rx_sync_p0;
    logic rx_sync_p1;
    logic rxs;

    uart_state_e       state;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_idx;
    logic [DATA_W-1:0] shift;

    // Preset to 1 so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sync_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_sync_p0 <= rx;
            rx_sync_p1 <= rx_sync_p0;
        end
    end

    assign rxs = rx_sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_done <= 1'b0;
            rx_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!rxs) state <= ST_START;
                end
                ST_START: begin
                    if (baud_cnt == HALF_LAST) begin
                        baud_cnt <= '0;
                        state    <= rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        shift    <= {rxs, shift[DATA_W-1:1]};
                        bit_idx  <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                // Leaving at the stop-bit centre re-arms for an early next start.
                ST_STOP: begin
                    if (baud_cnt == FULL_LAST) begin
                        baud_cnt <= '0;
                        if (rxs) begin
                            rx_data <= shift;
                            rx_done <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            rx_err  <= 1'b1;
                            state   <= ST_WAIT_HIGH;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart.sv
// Byte-wide UART, 8N1, LSB first. Receiver lives in uart_rx; the
// transmitter FSM is here. The two halves share no state.
module uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    uart_if.slave bus
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] DONE_AT   = CNT_W'(CLKS_PER_BIT - 2);

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (bus.rx),
        .rx_data (bus.rx_data),
        .rx_done (bus.rx_done),
        .rx_err  (bus.rx_err)
    );

    uart_state_e       tx_state;
    logic [CNT_W-1:0]  tx_cnt;
    logic [2:0]        tx_idx;
    logic [DATA_W-1:0] tx_shift;
    logic              tx_line;
    logic              tx_done_q;
    logic              tx_busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx_shift  <= '0;
            tx_line   <= 1'b1;
            tx_done_q <= 1'b0;
            tx_busy_q <= 1'b0;
        end else begin
            tx_done_q <= 1'b0;
            case (tx_state)
                // transmit is only looked at here, so requests while busy are dropped.
                ST_IDLE: begin
                    tx_cnt <= '0;
                    tx_idx <= '0;
                    if (bus.transmit) begin
                        tx_shift  <= bus.tx_data;
                        tx_line   <= 1'b0;
                        tx_busy_q <= 1'b1;
                        tx_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt   <= '0;
                        tx_line  <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_state <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt <= '0;
                        tx_idx <= tx_idx + 1'b1;
                        if (tx_idx == 3'd7) begin
                            tx_line  <= 1'b1;
                            tx_state <= ST_STOP;
                        end else begin
                            tx_line  <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                // tx_done is registered one count early so it lands in the final stop cycle.
                ST_STOP: begin
                    tx_done_q <= (tx_cnt == DONE_AT);
                    if (tx_cnt == FULL_LAST) begin
                        tx_cnt    <= '0;
                        tx_busy_q <= 1'b0;
                        tx_state  <= ST_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx      = tx_line;
    assign bus.tx_done = tx_done_q;
    assign bus.tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart.sv
// Scenario bench for uart at CLKS_PER_BIT=16: byte scoreboards for the rx
// strobes and for frames decoded off the tx pin, plus per-scenario checks.
module tb_uart;
    import uart_pkg::*;

    localparam int C = 16;

    logic clk = 1'b0;
    logic rst_n;

    uart_if bus();

    uart #(.CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_rx_done = 0;
    int n_rx_err  = 0;
    int n_tx_done = 0;
    int last_done_cyc = 0;

    logic [7:0] exp_rx[$];
    logic [7:0] got_rx[$];
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.rx_done === 1'b1) begin
            got_rx.push_back(bus.rx_data);
            n_rx_done++;
            last_done_cyc = cyc;
        end
        if (bus.rx_err === 1'b1) n_rx_err++;
        if (bus.tx_done === 1'b1) n_tx_done++;
    end

    // Decode frames from the tx pin at bit centres; a reset abandons the frame.
    initial begin : tx_mon
        logic [9:0] bits;
        bit         aborted;
        int         len;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.tx === 1'b0) begin
                aborted = 1'b0;
                bits    = '0;
                for (int k = 0; k < 10; k++) begin
                    len = (k == 0) ? C / 2 : C;
                    for (int j = 0; j < len && !aborted; j++) begin
                        @(negedge clk);
                        if (rst_n !== 1'b1) aborted = 1'b1;
                    end
                    if (aborted) break;
                    bits[k] = bus.tx;
                end
                if (!aborted) got_tx.push_back(bits[8:1]);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bits(input logic v, input int n);
        bus.rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop_v, input int stop_bits,
                           input bit good);
        if (good) exp_rx.push_back(b);
        drive_bits(1'b0, C);
        for (int i = 0; i < 8; i++) drive_bits(b[i], C);
        drive_bits(stop_v, C * stop_bits);
        bus.rx = 1'b1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.rx       = 1'b1;
        bus.transmit = 1'b0;
        bus.tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.tx, bus.rx_data, bus.rx_done, bus.rx_err, bus.tx_done, bus.tx_busy} !== 13'b1_00000000_0000) begin
            bad++;
            $display("FAIL reset_outputs: got tx=%b rx_data=%h strobes=%b%b%b busy=%b, want tx=1 rx_data=00 strobes=000 busy=0",
                     bus.tx, bus.rx_data, bus.rx_done, bus.rx_err, bus.tx_done, bus.tx_busy);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        total++;
        if ({bus.tx, bus.tx_busy, bus.rx_done, bus.rx_err} !== 4'b1000) begin
            bad++;
            $display("FAIL idle_after_reset: got tx/busy/rx_done/rx_err=%b want 1000",
                     {bus.tx, bus.tx_busy, bus.rx_done, bus.rx_err});
        end
    endtask

    task automatic test_rx_basic;
        int d0, e0, t0, lat;
        logic [7:0] e, g;
        d0 = n_rx_done; e0 = n_rx_err; t0 = cyc;
        send_rx(8'hA5, 1'b1, 1, 1'b1);
        repeat (C) @(negedge clk);
        lat = last_done_cyc - t0;
        total++;
        if (n_rx_done - d0 != 1) begin
            bad++; $display("FAIL rx_basic_count: got %0d rx_done pulses want 1", n_rx_done - d0);
        end
        total++;
        if (lat < 152 || lat > 156) begin
            bad++; $display("FAIL rx_basic_latency: got %0d cycles want 152..156", lat);
        end
        total++;
        if (n_rx_err != e0) begin
            bad++; $display("FAIL rx_basic_err: got %0d rx_err pulses want 0", n_rx_err - e0);
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL rx_basic_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_tx_basic;
        logic [9:0] frame;
        logic [2:0] want;
        int d0;
        logic [7:0] e, g;
        repeat (400) if (bus.tx_busy === 1'b1) @(negedge clk);
        d0    = n_tx_done;
        frame = {1'b1, 8'h3C, 1'b0};
        exp_tx.push_back(8'h3C);
        bus.tx_data  = 8'h3C;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
        for (int i = 0; i < 10 * C; i++) begin
            want = {frame[i / C], 1'b1, (i == 10 * C - 1)};
            total++;
            if ({bus.tx, bus.tx_busy, bus.tx_done} !== want) begin
                bad++;
                $display("FAIL tx_wave: cycle %0d got tx/busy/done=%b want %b", i,
                         {bus.tx, bus.tx_busy, bus.tx_done}, want);
            end
            @(negedge clk);
        end
        total++;
        if ({bus.tx, bus.tx_busy, bus.tx_done} !== 3'b100) begin
            bad++; $display("FAIL tx_end: got tx/busy/done=%b want 100", {bus.tx, bus.tx_busy, bus.tx_done});
        end
        repeat (4) @(negedge clk);
        total++;
        if (n_tx_done - d0 != 1) begin
            bad++; $display("FAIL tx_done_count: got %0d want 1", n_tx_done - d0);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL tx_basic_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_rx_framing;
        int d0, e0;
        logic [7:0] e, g;
        d0 = n_rx_done; e0 = n_rx_err;
        send_rx(8'h5A, 1'b0, 2, 1'b0);
        drive_bits(1'b1, C);
        total++;
        if (n_rx_err - e0 != 1 || n_rx_done != d0) begin
            bad++; $display("FAIL frame_err_strobes: got err=%0d done=%0d want err=1 done=0",
                            n_rx_err - e0, n_rx_done - d0);
        end
        total++;
        if (bus.rx_data !== 8'hA5) begin
            bad++; $display("FAIL frame_err_hold: got rx_data=%h want a5", bus.rx_data);
        end
        send_rx(8'h11, 1'b1, 1, 1'b1);
        drive_bits(1'b1, C);
        total++;
        if (n_rx_done - d0 != 1 || bus.rx_data !== 8'h11) begin
            bad++; $display("FAIL frame_recover: got done=%0d rx_data=%h want done=1 rx_data=11",
                            n_rx_done - d0, bus.rx_data);
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL frame_sb_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_rx_glitch;
        int d0, e0;
        logic [7:0] e, g;
        d0 = n_rx_done; e0 = n_rx_err;
        drive_bits(1'b0, 4);
        drive_bits(1'b1, 2 * C);
        total++;
        if (n_rx_done != d0 || n_rx_err != e0) begin
            bad++; $display("FAIL glitch_strobes: got done=%0d err=%0d want 0 0",
                            n_rx_done - d0, n_rx_err - e0);
        end
        send_rx(8'hFF, 1'b1, 1, 1'b1);
        drive_bits(1'b1, C);
        total++;
        if (n_rx_done - d0 != 1 || bus.rx_data !== 8'hFF) begin
            bad++; $display("FAIL glitch_recover: got done=%0d rx_data=%h want done=1 rx_data=ff",
                            n_rx_done - d0, bus.rx_data);
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL glitch_sb_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_loopback;
        logic [7:0] msgs [3] = '{8'h01, 8'h02, 8'h03};
        int d0;
        logic [7:0] e, g;
        bit saw_ee;
        d0 = n_tx_done;
        fork
            begin
                for (int k = 0; k < 3; k++) send_rx(msgs[k], 1'b1, 1, 1'b1);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    for (int n = 0; n < 400 && bus.rx_done !== 1'b1; n++) @(negedge clk);
                    total++;
                    if (bus.rx_done !== 1'b1) begin
                        bad++; $display("FAIL echo_wait: no rx_done for frame %0d within 400 cycles", k);
                    end
                    bus.tx_data = bus.rx_data;
                    exp_tx.push_back(msgs[k]);
                    for (int n = 0; n < 400 && bus.tx_busy === 1'b1; n++) @(negedge clk);
                    bus.transmit = 1'b1;
                    @(negedge clk);
                    bus.transmit = 1'b0;
                    if (k == 0) begin
                        repeat (40) @(negedge clk);
                        bus.tx_data  = 8'hEE;
                        bus.transmit = 1'b1;
                        @(negedge clk);
                        bus.transmit = 1'b0;
                    end
                end
            end
        join
        for (int n = 0; n < 400 && bus.tx_busy === 1'b1; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        saw_ee = 1'b0;
        foreach (got_tx[i]) if (got_tx[i] === 8'hEE) saw_ee = 1'b1;
        total++;
        if (saw_ee) begin bad++; $display("FAIL echo_ignored: got byte ee on tx want never"); end
        total++;
        if (n_tx_done - d0 != 3) begin
            bad++; $display("FAIL echo_done_count: got %0d want 3", n_tx_done - d0);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL echo_tx_byte: got %h want %h", g, e); end
        end
        total++;
        if (got_tx.size() != 0) begin
            bad++; $display("FAIL echo_tx_extra: got %0d extra frames want 0", got_tx.size());
        end
        while (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            g = (got_rx.size() > 0) ? got_rx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL echo_rx_byte: got %h want %h", g, e); end
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] rb;
        int d0, e0, t0;
        logic [7:0] e, g;
        rb = 8'h96;
        repeat (400) if (bus.tx_busy === 1'b1) @(negedge clk);
        bus.tx_data  = 8'h3C;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
        repeat (19) @(negedge clk);
        drive_bits(1'b0, C);
        for (int i = 0; i < 3; i++) drive_bits(rb[i], C);
        drive_bits(rb[3], 4);
        d0 = n_rx_done; e0 = n_rx_err; t0 = n_tx_done;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({bus.tx, bus.tx_busy, bus.rx_done, bus.rx_err, bus.tx_done} !== 5'b10000) begin
            bad++; $display("FAIL reset_async: got tx/busy/rx_done/rx_err/tx_done=%b want 10000",
                            {bus.tx, bus.tx_busy, bus.rx_done, bus.rx_err, bus.tx_done});
        end
        bus.rx = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (3 * C) @(negedge clk);
        total++;
        if (n_rx_done != d0 || n_rx_err != e0 || n_tx_done != t0) begin
            bad++; $display("FAIL reset_no_strobes: got rx_done=%0d rx_err=%0d tx_done=%0d want 0 0 0",
                            n_rx_done - d0, n_rx_err - e0, n_tx_done - t0);
        end
        total++;
        if ({bus.tx, bus.tx_busy, bus.rx_data} !== 10'b10_00000000) begin
            bad++; $display("FAIL reset_idle: got tx=%b busy=%b rx_data=%h want tx=1 busy=0 rx_data=00",
                            bus.tx, bus.tx_busy, bus.rx_data);
        end
        exp_tx.push_back(8'h80);
        bus.tx_data  = 8'h80;
        bus.transmit = 1'b1;
        @(negedge clk);
        bus.transmit = 1'b0;
        repeat (10 * C + 6) @(negedge clk);
        total++;
        if (n_tx_done - t0 != 1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_tx: got tx_done=%0d busy=%b want 1 0", n_tx_done - t0, bus.tx_busy);
        end
        while (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            g = (got_tx.size() > 0) ? got_tx.pop_front() : 8'hxx;
            total++;
            if (g !== e) begin bad++; $display("FAIL post_reset_byte: got %h want %h", g, e); end
        end
        total++;
        if (got_tx.size() != 0) begin
            bad++; $display("FAIL post_reset_extra: got %0d extra frames want 0", got_tx.size());
        end
    endtask

    initial begin
        test_reset();
        test_rx_basic();
        test_tx_basic();
        test_rx_framing();
        test_rx_glitch();
        test_loopback();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart.md
Name: uart

Overview:
- Byte-wide UART transceiver: 8 data bits, no parity, 1 stop bit, LSB first.
- Sits directly upstream of the boot loader.
- Turns the serial `rx` pin into `rx_data` plus a one-cycle `rx_done` strobe.
- Serialises `tx_data` onto `tx` when `transmit` pulses, then reports completion with a one-cycle `tx_done` strobe.
- Receiver and transmitter are independent and may run concurrently, so received bytes can be echoed back as ACKs.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200); legal values are ≥ 8.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous to clk, idle high
- tx  out  1  serial output, idle high
- rx_data  out  8  last correctly framed received byte
- rx_done  out  1  one-cycle pulse: `rx_data` is newly valid
- rx_err  out  1  one-cycle pulse: framing error (stop bit sampled low)
- tx_data  in  8  byte to send, sampled in the cycle `transmit`=1 is accepted
- transmit  in  1  send request, level or pulse
- tx_done  out  1  one-cycle pulse at the end of the stop bit
- tx_busy  out  1  high from acceptance through the cycle `tx_done` is high

Behaviour:
- Reset (`rst_n`=0, asynchronous):
  - `tx`=1; `rx_data`=0; `rx_done`=`rx_err`=`tx_done`=`tx_busy`=0.
  - Both FSMs go to IDLE and the synchroniser flops are set to 1.
  - Reset mid-frame abandons the frame: `tx` is high immediately and no strobe fires.
- Sync: `rx` passes through a 2-flop synchroniser (preset 1); all rx logic uses the synchronised value `rxs`.
- RX FSM: IDLE → START → DATA → STOP → (IDLE | WAIT_HIGH).
  - IDLE: `rxs`=0 → START with the bit counter cleared.
  - START: after CLKS_PER_BIT/2 cycles, resample. `rxs`=1 is a glitch → IDLE with no strobe; `rxs`=0 → DATA.
  - DATA: sample every CLKS_PER_BIT cycles at bit centres, 8 samples, shifted into a shift register LSB first.
  - STOP: sample after CLKS_PER_BIT more cycles.
    - `rxs`=1: `rx_data` ← shift register and `rx_done`=1 in the next cycle; → IDLE.
    - `rxs`=0: `rx_err`=1 in the next cycle; `rx_data` unchanged; → WAIT_HIGH.
  - WAIT_HIGH: stays until `rxs`=1, then → IDLE (break conditions produce exactly one `rx_err`).
  - Re-arm: RX re-arms at the stop-bit centre, so a following start edge half a bit later is caught.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: `transmit`=1 → latch `tx_data`, `tx_busy`=1, `tx`=0 on the next edge.
  - Bit timing: start bit, then 8 data bits LSB first, then stop bit (`tx`=1), each exactly CLKS_PER_BIT cycles.
  - Completion: in the last stop-bit cycle `tx_done`=1 and `tx_busy`=1; on the next edge → IDLE with `tx_busy`=0.
  - `transmit` is ignored while `tx_busy`=1, including the `tx_done` cycle. Held `transmit` restarts one cycle after `tx_done`.
  - Frame length from acceptance to `tx_done` edge: 10×CLKS_PER_BIT cycles.
- Counters: baud counter is ⌈log2(CLKS_PER_BIT)⌉ bits and reloads at 0, no free-running drift; bit index is 3 bits. Counters never wrap mid-bit.
- Simultaneous events: RX and TX share nothing; `rx_done` and `tx_done` may pulse in the same cycle.
- Overrun: `rx_data` is overwritten by the next good frame; there is no buffering, and the consumer must read within one frame time.

Decomposition:
- Package `uart_pkg`:
  - localparam default CLKS_PER_BIT.
  - RX and TX state encodings (IDLE, START, DATA, STOP, WAIT_HIGH).
  - Data width constant 8.
- One sub-module, `uart_rx`: synchroniser, RX FSM, `rx_data`/`rx_done`/`rx_err`.
- TX logic lives in the top level `uart`.

Test Plan (CLKS_PER_BIT=16):
- RX 0xA5, well-formed frame → exactly one `rx_done` pulse ≈154±2 cycles after the start falling edge; `rx_data`=0xA5; `rx_err` never high.
- `transmit` pulse with `tx_data`=0x3C → `tx` sequence 0,0,0,1,1,1,1,0,0,1, each level held 16 cycles; `tx_done` one pulse 160 cycles after acceptance; `tx_busy` high for 160 cycles.
- RX 0x5A with stop bit driven 0 for 2 bit times → one `rx_err` pulse, no `rx_done`, `rx_data` keeps its prior value 0xA5. A following good 0x11 frame → `rx_done`, `rx_data`=0x11.
- `rx` low for 4 cycles, then high → no `rx_done`, no `rx_err`. A normal 0xFF frame right after → `rx_data`=0xFF.
- Loopback echo: receive 0x01, 0x02, 0x03 back-to-back; testbench drives `transmit` on each `rx_done`. Also pulse `transmit` with `tx_data`=0xEE mid-frame → `tx` carries 0x01, 0x02, 0x03 in order and 0xEE never appears.
- Assert `rst_n`=0 during TX bit 4 of 0x3C and RX bit 3 → `tx`=1 immediately, `tx_busy`=0, no strobes. After release, a new 0x80 TX completes normally.
